// File: rtl/dmem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// dmem_bridge_pkg
// Shared definitions for the data-memory bridge:
//   - db_state_e        : bridge FSM state encoding (IDLE/REQ/DONE)
//   - DB_ABORT_PATTERN  : load result returned when a bus access times out
//   - is_word_aligned() : alignment test on the two address LSBs
// -----------------------------------------------------------------------------
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        DB_IDLE = 2'd0,
        DB_REQ  = 2'd1,
        DB_DONE = 2'd2
    } db_state_e;

    localparam logic [31:0] DB_ABORT_PATTERN = 32'hDEAD_BEEF;

    // Word accesses only: both byte-offset bits must be zero.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/dmem_bridge_timeout_counter.sv
// -----------------------------------------------------------------------------
// timeout_counter
// Counts cycles spent waiting for a bus acknowledge. Cleared when a new
// transaction is launched, advances while enabled, and flags expiry once the
// count reaches TIMEOUT-1 (i.e. during the TIMEOUT-th enabled cycle).
//
// Ports:
//   clk      in  : clock, rising edge
//   rst      in  : synchronous active-high reset
//   clr      in  : synchronous clear (takes priority over en)
//   en       in  : count enable
//   expired  out : count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == LAST_CNT);

    // Next-count logic; saturates at the expiry value so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
// Converts the single-cycle datapath's load/store request into a req/ack
// transaction on an external memory bus. While the transaction is in flight
// the bridge raises stall so the datapath holds the PC and suppresses its
// register write; the instruction retires in the DONE cycle.
// Misaligned accesses are dropped with an align_err pulse; a missing ack
// aborts the access after TIMEOUT cycles and sets the sticky bus_err flag.
//
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   mem_read, mem_write : datapath load / store request (both high => store)
//   addr, wdata         : byte address and store data from the datapath
//   read_data           : load result, valid in the retire (DONE) cycle
//   stall               : current instruction must not retire this cycle
//   bus_req, bus_we     : bus request (held until ack/abort) and direction
//   bus_addr, bus_wdata : registered word address and store data
//   bus_ack, bus_rdata  : slave completion pulse and read data
//   align_err           : misaligned access seen in IDLE (combinational)
//   bus_err             : sticky timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       read_data,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              align_err,
    output logic              bus_err
);

    db_state_e         state_q;
    db_state_e         state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_q;
    logic [31:0]       wdata_d;
    logic              we_q;
    logic              we_d;
    logic [31:0]       rdata_q;
    logic [31:0]       rdata_d;
    logic              err_q;
    logic              err_d;

    logic              access_s;
    logic              aligned_s;
    logic              tmo_clr_s;
    logic              tmo_en_s;
    logic              tmo_expired_s;

    assign access_s  = mem_read | mem_write;
    assign aligned_s = is_word_aligned(addr[1:0]);

    timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr_s),
        .en      (tmo_en_s),
        .expired (tmo_expired_s)
    );

    // Next-state and datapath-latch logic for the bridge FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        tmo_clr_s = 1'b0;
        tmo_en_s  = 1'b0;

        case (state_q)
            DB_IDLE: begin
                // Misaligned requests never leave IDLE: the write is dropped.
                if (access_s && aligned_s) begin
                    addr_d    = {addr[ADDR_W-1:2], 2'b00};
                    wdata_d   = wdata;
                    we_d      = mem_write;
                    tmo_clr_s = 1'b1;
                    state_d   = DB_REQ;
                end else begin
                    state_d   = DB_IDLE;
                end
            end
            DB_REQ: begin
                tmo_en_s = 1'b1;
                // An ack in the last allowed cycle still wins over the timeout.
                if (bus_ack) begin
                    rdata_d = we_q ? 32'h0000_0000 : bus_rdata;
                    state_d = DB_DONE;
                end else if (tmo_expired_s) begin
                    rdata_d = DB_ABORT_PATTERN;
                    err_d   = 1'b1;
                    state_d = DB_DONE;
                end else begin
                    state_d = DB_REQ;
                end
            end
            DB_DONE: begin
                // Request inputs are still present here; ignoring them keeps
                // the retiring instruction from launching a second access.
                state_d = DB_IDLE;
            end
            default: begin
                state_d = DB_IDLE;
            end
        endcase
    end

    // FSM state and latched transaction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DB_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= 32'h0000_0000;
            we_q    <= 1'b0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // stall and align_err must react in the same cycle the request appears.
    assign stall     = ((state_q == DB_IDLE) && access_s && aligned_s) ||
                       (state_q == DB_REQ);
    assign align_err = (state_q == DB_IDLE) && access_s && !aligned_s;
    assign read_data = (state_q == DB_DONE) ? rdata_q : 32'h0000_0000;

    assign bus_req   = (state_q == DB_REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bridge
// Two bridge instances share clock and reset: one with TIMEOUT=16 for normal
// and slow-slave traffic, one with TIMEOUT=4 for abort behaviour. Each access
// is checked cycle by cycle against expectations derived from the access
// rules (stall length, retire data, sticky error), followed by random traffic.
// -----------------------------------------------------------------------------
module tb_dmem_bridge;

    localparam logic [31:0] ABORT = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mr_s   [2];
    logic        mw_s   [2];
    logic        ack_s  [2];
    logic [31:0] addr_s [2];
    logic [31:0] wd_s   [2];
    logic [31:0] brd_s  [2];
    logic [31:0] rdata_o[2];
    logic [31:0] baddr_o[2];
    logic [31:0] bwd_o  [2];
    logic        stall_o[2];
    logic        breq_o [2];
    logic        bwe_o  [2];
    logic        aerr_o [2];
    logic        berr_o [2];

    int checks   = 0;
    int failures = 0;
    int tmo   [2];
    bit err_m [2];
    int tx_cnt[2];
    logic breq_prev[2];

    dmem_bridge #(.ADDR_W(32), .TIMEOUT(16)) u_dut16 (
        .clk(clk), .rst(rst), .mem_read(mr_s[0]), .mem_write(mw_s[0]),
        .addr(addr_s[0]), .wdata(wd_s[0]), .read_data(rdata_o[0]),
        .stall(stall_o[0]), .bus_req(breq_o[0]), .bus_we(bwe_o[0]),
        .bus_addr(baddr_o[0]), .bus_wdata(bwd_o[0]), .bus_ack(ack_s[0]),
        .bus_rdata(brd_s[0]), .align_err(aerr_o[0]), .bus_err(berr_o[0])
    );

    dmem_bridge #(.ADDR_W(32), .TIMEOUT(4)) u_dut4 (
        .clk(clk), .rst(rst), .mem_read(mr_s[1]), .mem_write(mw_s[1]),
        .addr(addr_s[1]), .wdata(wd_s[1]), .read_data(rdata_o[1]),
        .stall(stall_o[1]), .bus_req(breq_o[1]), .bus_we(bwe_o[1]),
        .bus_addr(baddr_o[1]), .bus_wdata(bwd_o[1]), .bus_ack(ack_s[1]),
        .bus_rdata(brd_s[1]), .align_err(aerr_o[1]), .bus_err(berr_o[1])
    );

    // Count bus transactions (rising edges of bus_req), sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                tx_cnt[i]    <= 0;
                breq_prev[i] <= 1'b0;
            end else begin
                if (breq_o[i] && !breq_prev[i]) tx_cnt[i] <= tx_cnt[i] + 1;
                breq_prev[i] <= breq_o[i];
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One cycle with no request; optionally a stray ack with random data.
    task automatic idle(input int d, input bit late_ack);
        mr_s[d]  = 1'b0;
        mw_s[d]  = 1'b0;
        ack_s[d] = late_ack;
        brd_s[d] = $urandom;
        #2;
        chk($sformatf("d%0d idle stall", d), {31'd0, stall_o[d]}, 32'd0);
        chk($sformatf("d%0d idle bus_req", d), {31'd0, breq_o[d]}, 32'd0);
        chk($sformatf("d%0d idle read_data", d), rdata_o[d], 32'd0);
        chk($sformatf("d%0d idle align_err", d), {31'd0, aerr_o[d]}, 32'd0);
        chk($sformatf("d%0d idle bus_err", d), {31'd0, berr_o[d]}, {31'd0, err_m[d]});
        next_cycle();
        ack_s[d] = 1'b0;
    endtask

    // Full access: cycle 0 in IDLE, then REQ cycles, then the DONE cycle.
    // k = REQ cycle carrying the ack (1..TIMEOUT), anything else = no ack.
    task automatic access(input int d, input bit wr, input bit rd,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int k, input logic [31:0] rdat);
        bit al, acc, to;
        int len;
        logic [31:0] exp_rd;
        mr_s[1-d]  = 1'b0;
        mw_s[1-d]  = 1'b0;
        ack_s[1-d] = 1'b0;
        mr_s[d]    = rd;
        mw_s[d]    = wr;
        addr_s[d]  = a;
        wd_s[d]    = wd;
        ack_s[d]   = 1'b0;
        al  = (a[1:0] == 2'b00);
        acc = rd | wr;
        #2;
        chk($sformatf("d%0d c0 stall", d), {31'd0, stall_o[d]}, {31'd0, acc & al});
        chk($sformatf("d%0d c0 align_err", d), {31'd0, aerr_o[d]}, {31'd0, acc & ~al});
        chk($sformatf("d%0d c0 bus_req", d), {31'd0, breq_o[d]}, 32'd0);
        chk($sformatf("d%0d c0 read_data", d), rdata_o[d], 32'd0);
        next_cycle();
        if (!(acc && al)) return;
        to  = (k < 1) || (k > tmo[d]);
        len = to ? tmo[d] : k;
        for (int j = 1; j <= len; j++) begin
            ack_s[d] = (j == k);
            brd_s[d] = (j == k) ? rdat : $urandom;
            #2;
            chk($sformatf("d%0d req%0d bus_req", d, j), {31'd0, breq_o[d]}, 32'd1);
            chk($sformatf("d%0d req%0d stall", d, j), {31'd0, stall_o[d]}, 32'd1);
            chk($sformatf("d%0d req%0d bus_addr", d, j), baddr_o[d], {a[31:2], 2'b00});
            chk($sformatf("d%0d req%0d bus_we", d, j), {31'd0, bwe_o[d]}, {31'd0, wr});
            chk($sformatf("d%0d req%0d bus_wdata", d, j), bwd_o[d], wd);
            chk($sformatf("d%0d req%0d read_data", d, j), rdata_o[d], 32'd0);
            next_cycle();
        end
        ack_s[d] = 1'b0;
        exp_rd = to ? ABORT : (wr ? 32'd0 : rdat);
        if (to) err_m[d] = 1'b1;
        #2;
        chk($sformatf("d%0d done stall", d), {31'd0, stall_o[d]}, 32'd0);
        chk($sformatf("d%0d done bus_req", d), {31'd0, breq_o[d]}, 32'd0);
        chk($sformatf("d%0d done read_data", d), rdata_o[d], exp_rd);
        chk($sformatf("d%0d done bus_err", d), {31'd0, berr_o[d]}, {31'd0, err_m[d]});
        next_cycle();
    endtask

    initial begin
        int c0;
        tmo[0] = 16;
        tmo[1] = 4;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mr_s[i] = 1'b0; mw_s[i] = 1'b0; ack_s[i] = 1'b0;
            addr_s[i] = 32'd0; wd_s[i] = 32'd0; brd_s[i] = 32'd0;
            err_m[i] = 1'b0;
        end
        next_cycle();
        next_cycle();
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst bus_req", {31'd0, breq_o[i]}, 32'd0);
            chk("rst bus_we", {31'd0, bwe_o[i]}, 32'd0);
            chk("rst bus_addr", baddr_o[i], 32'd0);
            chk("rst bus_wdata", bwd_o[i], 32'd0);
            chk("rst read_data", rdata_o[i], 32'd0);
            chk("rst bus_err", {31'd0, berr_o[i]}, 32'd0);
            chk("rst align_err", {31'd0, aerr_o[i]}, 32'd0);
            chk("rst stall", {31'd0, stall_o[i]}, 32'd0);
        end
        rst = 1'b0;
        next_cycle();

        // Aligned load, ack in the first REQ cycle.
        access(0, 1'b0, 1'b1, 32'h100, 32'h0, 1, 32'h1234_5678);
        idle(0, 1'b0);

        // Store with a slow slave: ack in the 5th REQ cycle, one transaction.
        c0 = tx_cnt[0];
        access(0, 1'b1, 1'b0, 32'h204, 32'hCAFE_F00D, 5, 32'h5555_AAAA);
        idle(0, 1'b0);
        chk("slow store tx count", tx_cnt[0], c0 + 1);

        // Misaligned load: no transaction at all.
        c0 = tx_cnt[0];
        access(0, 1'b0, 1'b1, 32'h102, 32'h0, 1, 32'h0);
        idle(0, 1'b0);
        idle(0, 1'b0);
        chk("misaligned tx count", tx_cnt[0], c0);

        // Timeout on the TIMEOUT=4 instance, then a late ack in IDLE.
        access(1, 1'b0, 1'b1, 32'h40, 32'h0, 0, 32'h0);
        idle(1, 1'b1);
        idle(1, 1'b0);

        // Reset asserted in the second REQ cycle.
        mr_s[1] = 1'b1; mw_s[1] = 1'b0; addr_s[1] = 32'h60; ack_s[1] = 1'b0;
        next_cycle();
        #2 chk("rstreq req1 bus_req", {31'd0, breq_o[1]}, 32'd1);
        next_cycle();
        rst = 1'b1;
        #2 chk("rstreq req2 bus_req", {31'd0, breq_o[1]}, 32'd1);
        next_cycle();
        rst = 1'b0;
        mr_s[1] = 1'b0;
        err_m[0] = 1'b0;
        err_m[1] = 1'b0;
        #2;
        chk("rstreq bus_req", {31'd0, breq_o[1]}, 32'd0);
        chk("rstreq bus_err", {31'd0, berr_o[1]}, 32'd0);
        chk("rstreq stall", {31'd0, stall_o[1]}, 32'd0);
        chk("rstreq bus_addr", baddr_o[1], 32'd0);
        next_cycle();
        access(1, 1'b0, 1'b1, 32'h80, 32'h0, 2, 32'h0BAD_F00D);
        idle(1, 1'b0);

        // Back-to-back loads: next access appears right after DONE.
        c0 = tx_cnt[0];
        access(0, 1'b0, 1'b1, 32'h10, 32'h0, 1, 32'h1111_0010);
        access(0, 1'b0, 1'b1, 32'h14, 32'h0, 2, 32'h2222_0014);
        idle(0, 1'b0);
        chk("back-to-back tx count", tx_cnt[0], c0 + 2);

        // Random traffic on both instances.
        for (int n = 0; n < 60; n++) begin
            int d, op, k;
            logic [31:0] a;
            d  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            k  = int'($urandom_range(0, tmo[d] + 1));
            access(d, op[1], op[0], a, $urandom, k, $urandom);
            if ($urandom_range(0, 1) == 1) idle(d, $urandom_range(0, 1) == 1);
        end
        idle(0, 1'b0);
        idle(1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
